perceptron3_backprop: RTL and testbench

//  Training-direction counterpart of the 3-input sigmoid perceptron: consumes the latched forward

---
 rtl/perceptron3_backprop.sv | 160 ++++++++++++++++
 tb/tb_perceptron3_backprop.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron3_backprop.sv
// perceptron3_backprop: one Q8.24 training step for a 3-input sigmoid perceptron, sequenced over a
// single shared multiplier. Defining PERCEPTRON_BP_ERR_EN adds err_a/b/c and the BP_A..BP_C states.
module perceptron3_backprop #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [DWIDTH-1:0] C,
  input  logic [DWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wb,
  input  logic [DWIDTH-1:0] wc,
  input  logic [DWIDTH-1:0] bias,
  input  logic [DWIDTH-1:0] y,
  input  logic [DWIDTH-1:0] err,
  input  logic [DWIDTH-1:0] lrate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] wa_n,
  output logic [DWIDTH-1:0] wb_n,
  output logic [DWIDTH-1:0] wc_n,
  output logic [DWIDTH-1:0] bias_n,
`ifdef PERCEPTRON_BP_ERR_EN
  output logic [DWIDTH-1:0] err_a,
  output logic [DWIDTH-1:0] err_b,
  output logic [DWIDTH-1:0] err_c,
`endif
  output logic [3:0]        state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high. in_ready is
  // high only in IDLE; out_valid is high only in DONE and holds results stable until out_ready.
  typedef enum logic [3:0] {
    IDLE, DERIV, DELTA, SCALE, UPD_A, UPD_B, UPD_C,
`ifdef PERCEPTRON_BP_ERR_EN
    BP_A, BP_B, BP_C,
`endif
    DONE
  } state_t;

  localparam logic [DWIDTH-1:0] ONE  = DWIDTH'(1) << FRAC;
  localparam logic [DWIDTH-1:0] SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SMIN = {1'b1, {(DWIDTH-1){1'b0}}};

  function automatic logic [DWIDTH-1:0] fx_mul(input logic [DWIDTH-1:0] p,
                                               input logic [DWIDTH-1:0] q);
    logic signed [2*DWIDTH-1:0] prod;
    logic signed [2*DWIDTH-1:0] shf;
    prod = $signed({{DWIDTH{p[DWIDTH-1]}}, p}) * $signed({{DWIDTH{q[DWIDTH-1]}}, q});
    shf  = prod >>> FRAC;
    // In range only when every bit above the result sign matches it.
    if (&shf[2*DWIDTH-1:DWIDTH-1] || ~|shf[2*DWIDTH-1:DWIDTH-1]) fx_mul = shf[DWIDTH-1:0];
    else fx_mul = shf[2*DWIDTH-1] ? SMIN : SMAX;
  endfunction

  function automatic logic [DWIDTH-1:0] fx_sub(input logic [DWIDTH-1:0] p,
                                               input logic [DWIDTH-1:0] q);
    logic [DWIDTH:0] diff;
    diff = {p[DWIDTH-1], p} - {q[DWIDTH-1], q};
    if (diff[DWIDTH] == diff[DWIDTH-1]) fx_sub = diff[DWIDTH-1:0];
    else fx_sub = diff[DWIDTH] ? SMIN : SMAX;
  endfunction

  state_t state, state_nx;
  logic [DWIDTH-1:0] ra, rb, rc, rwa, rwb, rwc, rbias, ry, rerr, rlr;
  logic [DWIDTH-1:0] s_r, d_r, l_r;
  logic [DWIDTH-1:0] mul_a, mul_b, mul_out;

  assign state_dbg = state;
  assign mul_out   = fx_mul(mul_a, mul_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = DERIV;
      DERIV: state_nx = DELTA;
      DELTA: state_nx = SCALE;
      SCALE: state_nx = UPD_A;
      UPD_A: state_nx = UPD_B;
      UPD_B: state_nx = UPD_C;
`ifdef PERCEPTRON_BP_ERR_EN
      UPD_C: state_nx = BP_A;
      BP_A:  state_nx = BP_B;
      BP_B:  state_nx = BP_C;
      BP_C:  state_nx = DONE;
`else
      UPD_C: state_nx = DONE;
`endif
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand steering for the one shared multiplier.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      DERIV: begin mul_a = ry;    mul_b = fx_sub(ONE, ry); end
      DELTA: begin mul_a = rerr;  mul_b = s_r;             end
      SCALE: begin mul_a = rlr;   mul_b = d_r;             end
      UPD_A: begin mul_a = l_r;   mul_b = ra;              end
      UPD_B: begin mul_a = l_r;   mul_b = rb;              end
      UPD_C: begin mul_a = l_r;   mul_b = rc;              end
`ifdef PERCEPTRON_BP_ERR_EN
      BP_A:  begin mul_a = d_r;   mul_b = rwa;             end
      BP_B:  begin mul_a = d_r;   mul_b = rwb;             end
      BP_C:  begin mul_a = d_r;   mul_b = rwc;             end
`endif
      default: ;
    endcase
  end

  // Back-propagated errors read rwa/rwb/rwc, the pre-update weights.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra <= '0; rb <= '0; rc <= '0; rwa <= '0; rwb <= '0; rwc <= '0;
      rbias <= '0; ry <= '0; rerr <= '0; rlr <= '0;
      s_r <= '0; d_r <= '0; l_r <= '0;
      wa_n <= '0; wb_n <= '0; wc_n <= '0; bias_n <= '0;
`ifdef PERCEPTRON_BP_ERR_EN
      err_a <= '0; err_b <= '0; err_c <= '0;
`endif
    end else begin
      if (in_valid && in_ready) begin
        ra <= A; rb <= B; rc <= C; rwa <= wa; rwb <= wb; rwc <= wc;
        rbias <= bias; ry <= y; rerr <= err; rlr <= lrate;
      end
      case (state)
        DERIV: s_r <= mul_out;
        DELTA: d_r <= mul_out;
        SCALE: l_r <= mul_out;
        UPD_A: begin
          wa_n   <= fx_sub(rwa, mul_out);
          bias_n <= fx_sub(rbias, l_r);
        end
        UPD_B: wb_n <= fx_sub(rwb, mul_out);
        UPD_C: wc_n <= fx_sub(rwc, mul_out);
`ifdef PERCEPTRON_BP_ERR_EN
        BP_A:  err_a <= mul_out;
        BP_B:  err_b <= mul_out;
        BP_C:  err_c <= mul_out;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron3_backprop.sv
// tb_perceptron3_backprop: directed and random training steps through perceptron3_backprop,
// results checked against a queue of expected words. Honours PERCEPTRON_BP_ERR_EN.
module tb_perceptron3_backprop;
  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h0100_0000;
`ifdef PERCEPTRON_BP_ERR_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 7;
`endif

  typedef struct {
    logic [W-1:0] a, b, c, wa, wb, wc, bias, y, err, lr;
  } op_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, C, wa, wb, wc, bias, y, err, lrate;
  logic [W-1:0] wa_n, wb_n, wc_n, bias_n;
  logic [3:0]   state_dbg;
`ifdef PERCEPTRON_BP_ERR_EN
  logic [W-1:0] err_a, err_b, err_c;
`endif

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int cyc = 0, acc_cyc = 0;
  logic [W-1:0] exp_q[$];

  perceptron3_backprop #(.DWIDTH(W), .FRAC(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .wa(wa), .wb(wb), .wc(wc), .bias(bias), .y(y), .err(err),
    .lrate(lrate), .out_valid(out_valid), .out_ready(out_ready),
    .wa_n(wa_n), .wb_n(wb_n), .wc_n(wc_n), .bias_n(bias_n),
`ifdef PERCEPTRON_BP_ERR_EN
    .err_a(err_a), .err_b(err_b), .err_c(err_c),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset-independent cycle bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && in_valid && in_ready) acc_cyc <= cyc;
  end

  // Reference arithmetic in 64-bit integers
  function automatic logic [W-1:0] clamp(input longint v);
    if (v > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [W-1:0] m_mul(input logic [W-1:0] p, input logic [W-1:0] q);
    longint p64, q64;
    p64 = longint'($signed(p));
    q64 = longint'($signed(q));
    return clamp((p64 * q64) >>> 24);
  endfunction

  function automatic logic [W-1:0] m_sub(input logic [W-1:0] p, input logic [W-1:0] q);
    return clamp(longint'($signed(p)) - longint'($signed(q)));
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a = $urandom; o.b = $urandom; o.c = $urandom;
    o.wa = $urandom_range(0, 32'h07FF_FFFF) - 32'h0400_0000;
    o.wb = $urandom; o.wc = $urandom; o.bias = $urandom;
    o.y = $urandom_range(0, 32'h0100_0000);
    o.err = $urandom; o.lr = $urandom_range(0, 32'h0100_0000);
    return o;
  endfunction

  // Driver tasks
  task automatic apply_op(input op_t o);
    A = o.a; B = o.b; C = o.c; wa = o.wa; wb = o.wb; wc = o.wc;
    bias = o.bias; y = o.y; err = o.err; lrate = o.lr;
  endtask

  task automatic scramble();
    apply_op(rand_op());
    in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic push_vals(input logic [W-1:0] e_wa, input logic [W-1:0] e_wb,
                           input logic [W-1:0] e_wc, input logic [W-1:0] e_bias,
                           input logic [W-1:0] e_ea, input logic [W-1:0] e_eb,
                           input logic [W-1:0] e_ec);
    exp_q.push_back(e_wa); exp_q.push_back(e_wb);
    exp_q.push_back(e_wc); exp_q.push_back(e_bias);
`ifdef PERCEPTRON_BP_ERR_EN
    exp_q.push_back(e_ea); exp_q.push_back(e_eb); exp_q.push_back(e_ec);
`else
    if (e_ea === 'x && e_eb === 'x && e_ec === 'x) exp_q.push_back('x);
`endif
  endtask

  task automatic push_model(input op_t o);
    logic [W-1:0] s, d, l;
    s = m_mul(o.y, m_sub(ONE, o.y));
    d = m_mul(o.err, s);
    l = m_mul(o.lr, d);
    push_vals(m_sub(o.wa, m_mul(l, o.a)), m_sub(o.wb, m_mul(l, o.b)),
              m_sub(o.wc, m_mul(l, o.c)), m_sub(o.bias, l),
              m_mul(d, o.wa), m_mul(d, o.wb), m_mul(d, o.wc));
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pop_exp(output logic [W-1:0] v);
    v = 'x;
    if (exp_q.size() > 0) v = exp_q.pop_front();
  endtask

  task automatic check_results(input string tag);
    logic [W-1:0] e;
    pop_exp(e); check({tag, ":wa_n"}, wa_n, e);
    pop_exp(e); check({tag, ":wb_n"}, wb_n, e);
    pop_exp(e); check({tag, ":wc_n"}, wc_n, e);
    pop_exp(e); check({tag, ":bias_n"}, bias_n, e);
`ifdef PERCEPTRON_BP_ERR_EN
    pop_exp(e); check({tag, ":err_a"}, err_a, e);
    pop_exp(e); check({tag, ":err_b"}, err_b, e);
    pop_exp(e); check({tag, ":err_c"}, err_c, e);
`endif
  endtask

  // Leaves the caller at the negedge just after the accepting edge.
  task automatic send(input string tag, input op_t o);
    int n = 0;
    apply_op(o);
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input bit scr);
    int n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      if (scr) scramble();
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(LAT));
    check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  op_t t1, t2, op;
  int prev_acc;

  initial begin
    t1 = '{a: 32'h0100_0000, b: 32'hFF00_0000, c: 32'h0, wa: 32'h0040_0000, wb: 32'h0080_0000,
           wc: 32'hFF00_0000, bias: 32'h0, y: 32'h0080_0000, err: 32'h0100_0000,
           lr: 32'h0080_0000};
    t2 = '{a: ONE, b: 32'h0, c: 32'h0, wa: 32'h0, wb: 32'h0, wc: 32'h0, bias: 32'h8000_0000,
           y: 32'h0080_0000, err: 32'h7F00_0000, lr: 32'h7F00_0000};

    // Reset state
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply_op(t1);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:wa_n", wa_n, 32'h0);
    check("rst:bias_n", bias_n, 32'h0);
    check("rst:state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Test 1: nominal
    push_vals(32'h0020_0000, 32'h00A0_0000, 32'hFF00_0000, 32'hFFE0_0000,
              32'h0010_0000, 32'h0020_0000, 32'hFFC0_0000);
    send("nom", t1);
    wait_valid("nom", 1'b0);
    check_results("nom");
    release_out();
    check("nom:idle_in_ready", 32'(in_ready), 32'd1);
    check("nom:idle_out_valid", 32'(out_valid), 32'd0);
    check("nom:kept_wb_n", wb_n, 32'h00A0_0000);

    // Test 2: saturation
    push_vals(32'h8000_0001, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    send("sat", t2);
    wait_valid("sat", 1'b0);
    check_results("sat");
    release_out();

    // Test 3: backpressure with inputs toggling while busy and in DONE
    push_vals(32'h0020_0000, 32'h00A0_0000, 32'hFF00_0000, 32'hFFE0_0000,
              32'h0010_0000, 32'h0020_0000, 32'hFFC0_0000);
    send("bp", t1);
    wait_valid("bp", 1'b1);
    for (int i = 0; i < 20; i++) begin
      scramble();
      @(negedge clk);
      check("bp:out_valid", 32'(out_valid), 32'd1);
      check("bp:in_ready", 32'(in_ready), 32'd0);
      check("bp:wa_n", wa_n, exp_q[0]);
      check("bp:bias_n", bias_n, exp_q[3]);
    end
    in_valid = 1'b0;
    check_results("bp");
    release_out();
    check("bp:after_in_ready", 32'(in_ready), 32'd1);
    check("bp:after_out_valid", 32'(out_valid), 32'd0);

    // Test 4: back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      op = rand_op();
      apply_op(op);
      push_model(op);
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      if (k > 0) check("b2b:period", 32'(acc_cyc - prev_acc), 32'(LAT + 1));
      prev_acc = acc_cyc;
      wait_valid("b2b", 1'b0);
      check_results("b2b");
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Test 5: reset in UPD_B
    send("rmid", t1);
    repeat (4) @(negedge clk);
    check("rmid:state_updb", 32'(state_dbg), 32'd5);
    rst = 1'b0;
    #1;
    check("rmid:out_valid", 32'(out_valid), 32'd0);
    check("rmid:in_ready", 32'(in_ready), 32'd1);
    check("rmid:wa_n", wa_n, 32'h0);
    check("rmid:bias_n", bias_n, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rmid:out_valid_rel", 32'(out_valid), 32'd0);
    push_vals(32'h0020_0000, 32'h00A0_0000, 32'hFF00_0000, 32'hFFE0_0000,
              32'h0010_0000, 32'h0020_0000, 32'hFFC0_0000);
    send("rmid_t1", t1);
    wait_valid("rmid_t1", 1'b0);
    check_results("rmid_t1");
    release_out();

    // Test 6: y = ONE leaves everything unchanged and zero errors
    op = rand_op();
    op.y = ONE;
    op.lr = 32'h0100_0000;
    push_vals(op.wa, op.wb, op.wc, op.bias, 32'h0, 32'h0, 32'h0);
    send("yone", op);
    wait_valid("yone", 1'b0);
    check_results("yone");
    release_out();

    // lrate = 0 keeps weights/bias exactly
    op = rand_op();
    op.lr = 32'h0;
    push_vals(op.wa, op.wb, op.wc, op.bias,
              m_mul(m_mul(op.err, m_mul(op.y, m_sub(ONE, op.y))), op.wa),
              m_mul(m_mul(op.err, m_mul(op.y, m_sub(ONE, op.y))), op.wb),
              m_mul(m_mul(op.err, m_mul(op.y, m_sub(ONE, op.y))), op.wc));
    send("lr0", op);
    wait_valid("lr0", 1'b0);
    check_results("lr0");
    release_out();

    // Random operand sets against the model
    for (int k = 0; k < 3; k++) begin
      op = rand_op();
      push_model(op);
      send("rnd", op);
      wait_valid("rnd", 1'b0);
      check_results("rnd");
      release_out();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
